// File: rtl/reg_bank_wb.sv
`default_nettype none
// ============================================================================
// Module      : reg_bank_wb
// Description : 32x32 MIPS register file with two combinational read ports,
//               a hard-wired $zero, and a sticky out-of-range write flag.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_bank_wb #(
    parameter logic [31:0] SP_INIT = 32'd227,
    parameter logic [31:0] RA_INIT = 32'd0,
    parameter int          BYPASS  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        reg_write,
    input  logic [31:0] write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    output logic        addr_err,
    output logic [4:0]  last_wr_idx
);

    localparam bit c_bypass = (BYPASS != 0);

    logic        w_wr_legal;
    logic        w_wr_illegal;
    logic [4:0]  w_wr_idx;
    logic [31:0] w_regs [32];
    logic        r_addr_err;
    logic [4:0]  r_last_wr_idx;

    // Upper index bits are checked, never truncated; index 0 is legal but a no-op.
    assign w_wr_idx     = write_reg[4:0];
    assign w_wr_legal   = reg_write && (write_reg[31:5] == 27'd0) && (w_wr_idx != 5'd0);
    assign w_wr_illegal = reg_write && (write_reg[31:5] != 27'd0);

    assign w_regs[0] = 32'd0;

    for (genvar i = 1; i < 32; i++) begin : g_regs
        localparam logic [31:0] c_rst_val = (i == 29) ? SP_INIT :
                                            (i == 31) ? RA_INIT : 32'd0;
        logic [31:0] r_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_q <= c_rst_val;
            end else if (w_wr_legal && (w_wr_idx == 5'(i))) begin
                r_q <= write_data;
            end
        end

        assign w_regs[i] = r_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr_err    <= 1'b0;
            r_last_wr_idx <= 5'd0;
        end else begin
            if (w_wr_illegal) begin
                r_addr_err <= 1'b1;
            end
            if (w_wr_legal) begin
                r_last_wr_idx <= w_wr_idx;
            end
        end
    end

    // Write-first forwarding only applies to legal nonzero destinations.
    always_comb begin
        read_data1 = w_regs[read_reg1];
        read_data2 = w_regs[read_reg2];
        if (c_bypass && w_wr_legal && (w_wr_idx == read_reg1)) begin
            read_data1 = write_data;
        end
        if (c_bypass && w_wr_legal && (w_wr_idx == read_reg2)) begin
            read_data2 = write_data;
        end
    end

    assign addr_err    = r_addr_err;
    assign last_wr_idx = r_last_wr_idx;

endmodule
`default_nettype wire

// File: tb/tb_reg_bank_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_bank_wb
// Description : Directed bench for reg_bank_wb, write-first and stored-value
//               read variants side by side on shared stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_bank_wb;

    logic        clk;
    logic        reset;
    logic        reg_write;
    logic [31:0] write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] rd1_b1, rd2_b1, rd1_b0, rd2_b0;
    logic        err_b1, err_b0;
    logic [4:0]  lwi_b1, lwi_b0;

    int checks = 0;
    int errors = 0;

    reg_bank_wb #(.SP_INIT(32'd227), .RA_INIT(32'd0), .BYPASS(1)) u_dut_b1 (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b1), .read_data2(rd2_b1), .addr_err(err_b1),
        .last_wr_idx(lwi_b1)
    );

    reg_bank_wb #(.SP_INIT(32'd227), .RA_INIT(32'd0), .BYPASS(0)) u_dut_b0 (
        .clk(clk), .reset(reset), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(rd1_b0), .read_data2(rd2_b0), .addr_err(err_b0),
        .last_wr_idx(lwi_b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [4:0] b);
        read_reg1 = a;
        read_reg2 = b;
        #1;
    endtask

    initial begin
        logic [31:0] exp_rst;
        reset = 1'b1; reg_write = 1'b0; write_reg = 32'd0; write_data = 32'd0;
        read_reg1 = 5'd0; read_reg2 = 5'd0;
        tick();
        reset = 1'b0;

        // Reset contents of every index on both ports
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i));
            exp_rst = (i == 29) ? 32'd227 : 32'd0;
            chk($sformatf("rst_rd1_b1[%0d]", i), rd1_b1, exp_rst);
            chk($sformatf("rst_rd1_b0[%0d]", i), rd1_b0, exp_rst);
            exp_rst = ((31 - i) == 29) ? 32'd227 : 32'd0;
            chk($sformatf("rst_rd2_b1[%0d]", 31 - i), rd2_b1, exp_rst);
        end
        chk("rst_addr_err", 32'(err_b1), 32'd0);
        chk("rst_last_wr_idx", 32'(lwi_b1), 32'd0);

        // Basic write/read
        reg_write = 1'b1; write_reg = 32'd8; write_data = 32'hDEADBEEF;
        tick();
        reg_write = 1'b0;
        rd(5'd8, 5'd8);
        chk("wr8_rd1", rd1_b1, 32'hDEADBEEF);
        chk("wr8_rd2", rd2_b1, 32'hDEADBEEF);
        chk("wr8_rd1_b0", rd1_b0, 32'hDEADBEEF);
        chk("wr8_last_idx", 32'(lwi_b1), 32'd8);

        // Index 0 discarded, $ra writable
        reg_write = 1'b1; write_reg = 32'd0; write_data = 32'h1234;
        tick();
        reg_write = 1'b0;
        rd(5'd0, 5'd8);
        chk("wr0_rd", rd1_b1, 32'd0);
        chk("wr0_last_idx", 32'(lwi_b1), 32'd8);
        chk("wr0_err", 32'(err_b1), 32'd0);
        reg_write = 1'b1; write_reg = 32'd31; write_data = 32'h0040_0010;
        tick();
        reg_write = 1'b0;
        rd(5'd31, 5'd0);
        chk("wr31_rd", rd1_b1, 32'h0040_0010);
        chk("wr31_last_idx", 32'(lwi_b1), 32'd31);

        // Out-of-range destinations
        reg_write = 1'b1; write_reg = 32'd32; write_data = 32'd5;
        tick();
        write_reg = 32'hFFFF_FFFF;
        tick();
        reg_write = 1'b0;
        rd(5'd0, 5'd31);
        chk("oor_reg0", rd1_b1, 32'd0);
        chk("oor_reg31", rd2_b1, 32'h0040_0010);
        chk("oor_err", 32'(err_b1), 32'd1);
        chk("oor_err_b0", 32'(err_b0), 32'd1);
        chk("oor_last_idx", 32'(lwi_b1), 32'd31);
        reg_write = 1'b1; write_reg = 32'd3; write_data = 32'd3;
        tick();
        reg_write = 1'b0;
        rd(5'd3, 5'd31);
        chk("oor_legal_rd3", rd1_b1, 32'd3);
        chk("oor_err_sticky", 32'(err_b1), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rd(5'd8, 5'd31);
        chk("rst2_err", 32'(err_b1), 32'd0);
        chk("rst2_last_idx", 32'(lwi_b1), 32'd0);
        chk("rst2_reg8", rd1_b1, 32'd0);
        chk("rst2_reg31", rd2_b1, 32'd0);

        // Bypass behaviour
        reg_write = 1'b1; write_reg = 32'd10; write_data = 32'd7;
        tick();
        write_data = 32'd9;
        rd(5'd10, 5'd10);
        chk("byp1_rd1", rd1_b1, 32'd9);
        chk("byp1_rd2", rd2_b1, 32'd9);
        chk("byp0_rd1_pre", rd1_b0, 32'd7);
        chk("byp0_rd2_pre", rd2_b0, 32'd7);
        tick();
        reg_write = 1'b0;
        #1;
        chk("byp0_rd1_post", rd1_b0, 32'd9);
        chk("byp1_rd1_post", rd1_b1, 32'd9);
        reg_write = 1'b1; write_reg = 32'd42; write_data = 32'd100;
        rd(5'd10, 5'd10);
        chk("byp_illegal_rd1", rd1_b1, 32'd9);
        write_reg = 32'd0;
        rd(5'd0, 5'd10);
        chk("byp_zero_rd1", rd1_b1, 32'd0);
        reg_write = 1'b0;
        #1;

        // Reset and write on the same edge
        reset = 1'b1; reg_write = 1'b1; write_reg = 32'd29; write_data = 32'd0;
        tick();
        reset = 1'b0; reg_write = 1'b0;
        rd(5'd29, 5'd10);
        chk("coll_reg29", rd1_b1, 32'd227);
        chk("coll_reg10", rd2_b1, 32'd0);
        chk("coll_last_idx", 32'(lwi_b1), 32'd0);
        reset = 1'b1; reg_write = 1'b1; write_reg = 32'd40; write_data = 32'd5;
        tick();
        reset = 1'b0; reg_write = 1'b0;
        #1;
        chk("coll_err", 32'(err_b1), 32'd0);
        chk("coll_err_b0", 32'(err_b0), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
